// File: rtl/disp_pkg.sv
// disp_pkg: shared active-low glyph and digit-select constants for the display scanner.
package disp_pkg;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] DGT_OFF   = 4'b1111;
endpackage

// File: rtl/seg7_hex.sv
// seg7_hex: hex nibble to active-low {g,f,e,d,c,b,a} glyph decode.
module seg7_hex
  import disp_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  always_comb begin
    seg_o = SEG_BLANK;
    case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 4-digit multiplexed 7-seg scanner with frame-synchronous double buffer.
// Brightness dimming (bright port) is built only with DISP_SCAN_DIMMING_EN defined.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic        lz_en,
`ifdef DISP_SCAN_DIMMING_EN
  input  logic [2:0]  bright,
`endif
  output logic [3:0]  dgt,
  output logic [6:0]  seg,
  output logic        pending,
  output logic        frame_tick
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] BLANK = DW'(BLANK_CYC);
  logic [DW-1:0] div_q, div_d;
  logic [1:0] slot_q, slot_d;
  logic [15:0] shadow_q, shadow_d, active_q, active_d;
  logic pending_q, pending_d, tick_q, wrap, frame_end, lit, supp;
  logic [3:0] dgt_q, dgt_d, nib;
  logic [6:0] seg_q, seg_d, glyph;
`ifdef DISP_SCAN_DIMMING_EN
  logic [31:0] post, on_lim;
  assign post   = 32'(div_q) - 32'(BLANK_CYC);
  assign on_lim = 32'(((SCAN_DIV - BLANK_CYC) * (int'(bright) + 1)) / 8);
  assign lit    = div_q >= BLANK && post < on_lim;
`else
  assign lit = div_q >= BLANK;
`endif
  seg7_hex u_hex (.hex_i(nib), .seg_o(glyph));
  always_comb begin
    wrap      = div_q == DIV_LAST;
    frame_end = wrap && slot_q == 2'd3;
    div_d     = wrap ? '0 : div_q + 1'b1;
    slot_d    = wrap ? slot_q + 2'd1 : slot_q;
    shadow_d  = load ? digits_in : shadow_q;
    // a load landing on the frame boundary bypasses the shadow entirely
    active_d  = frame_end ? (load ? digits_in : pending_q ? shadow_q : active_q) : active_q;
    pending_d = frame_end ? 1'b0 : load | pending_q;
    nib       = active_q[{slot_q, 2'b00} +: 4];
    supp      = lz_en && (slot_q == 2'd3 ? active_q[15:12] == 4'h0 :
                          slot_q == 2'd2 ? active_q[15:8] == 8'h0 :
                          slot_q == 2'd1 ? active_q[15:4] == 12'h0 : 1'b0);
    dgt_d     = lit ? ~(4'b0001 << slot_q) : DGT_OFF;
    seg_d     = supp ? SEG_BLANK : glyph;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q     <= '0;
      slot_q    <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      tick_q    <= 1'b0;
      dgt_q     <= DGT_OFF;
      seg_q     <= SEG_BLANK;
    end else begin
      div_q     <= div_d;
      slot_q    <= slot_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      tick_q    <= frame_end;
      dgt_q     <= dgt_d;
      seg_q     <= seg_d;
    end
  end
  assign dgt        = dgt_q;
  assign seg        = seg_q;
  assign pending    = pending_q;
  assign frame_tick = tick_q;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: randomized and directed checks of disp_scan_ctrl against a frame-position model.
module tb_disp_scan_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, lz_en = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic [2:0] bright = 3'd7;
  logic [3:0] dgt;
  logic [6:0] seg;
  logic pending, frame_tick;
  int checks = 0, passed = 0;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  always #5 clk = ~clk;

  disp_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in), .lz_en(lz_en),
`ifdef DISP_SCAN_DIMMING_EN
    .bright(bright),
`endif
    .dgt(dgt), .seg(seg), .pending(pending), .frame_tick(frame_tick)
  );

  // model: n counts clocks since reset release; a frame is 32 positions of 8-cycle slots
  int n;
  logic [15:0] m_act, m_sh;
  logic m_pend, m_tick;
  logic [3:0] m_dgt;
  logic [6:0] m_seg;

  function automatic logic [6:0] f_seg(logic [15:0] a, int p, logic lz);
    int s = p / 8;
    int up = int'(a) >> (4 * s);
    return (lz && s > 0 && up == 0) ? 7'h7F : GLYPH[up % 16];
  endfunction

  function automatic logic [3:0] f_dgt(int p, int b);
    int d = p % 8;
    return (d >= 2 && d - 2 < 6 * (b + 1) / 8) ? 4'hF ^ (4'b0001 << (p / 8)) : 4'hF;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      n <= 0; m_act <= 16'h0; m_sh <= 16'h0; m_pend <= 1'b0;
      m_tick <= 1'b0; m_dgt <= 4'hF; m_seg <= 7'h7F;
    end else begin
      m_seg  <= f_seg(m_act, n % 32, lz_en);
      m_dgt  <= f_dgt(n % 32, int'(bright));
      m_tick <= n % 32 == 31;
      if (n % 32 == 31) begin
        m_act  <= load ? digits_in : m_pend ? m_sh : m_act;
        m_pend <= 1'b0;
      end else if (load) begin
        m_sh   <= digits_in;
        m_pend <= 1'b1;
      end
      n <= n + 1;
    end
  end

  task automatic test_reset;
    rst_n = 1'b0; load = 1'b1; digits_in = 16'hFFFF;
    repeat (3) begin
      @(negedge clk);
      checks++; if (dgt !== 4'hF) $display("FAIL reset_dgt: got %b want 1111", dgt); else passed++;
      checks++; if (seg !== 7'h7F) $display("FAIL reset_seg: got %h want 7f", seg); else passed++;
      checks++; if (pending !== 1'b0) $display("FAIL reset_pending: got %b want 0", pending); else passed++;
    end
    load = 1'b0; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (dgt !== 4'b1110) $display("FAIL post_reset_dgt: got %b want 1110", dgt); else passed++;
    checks++; if (seg !== 7'h40) $display("FAIL post_reset_seg: got %h want 40", seg); else passed++;
    checks++; if (pending !== 1'b0) $display("FAIL post_reset_pending: got %b want 0", pending); else passed++;
  endtask

  task automatic test_scan;
    int ticks = 0;
    repeat (32) begin
      @(negedge clk);
      if (frame_tick) ticks++;
      checks++; if (dgt !== m_dgt) $display("FAIL scan_dgt: got %b want %b", dgt, m_dgt); else passed++;
      checks++; if (frame_tick !== m_tick) $display("FAIL scan_tick: got %b want %b", frame_tick, m_tick); else passed++;
    end
    checks++; if (ticks != 1) $display("FAIL scan_tick_count: got %0d want 1", ticks); else passed++;
  endtask

  task automatic test_double_buffer;
    logic got = 1'b0;
    for (int k = 0; k < 40 && n % 32 != 12; k++) @(negedge clk);
    load = 1'b1; digits_in = 16'h1234;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      load = 1'b0;
      if (frame_tick) got = 1'b1;
      else begin
        checks++; if (seg !== 7'h40) $display("FAIL dbuf_hold_seg: got %h want 40", seg); else passed++;
        checks++; if (pending !== 1'b1) $display("FAIL dbuf_pending: got %b want 1", pending); else passed++;
      end
    end
    checks++; if (!got) $display("FAIL dbuf_tick_timeout: got no tick want tick"); else passed++;
    @(negedge clk);
    checks++; if (seg !== 7'h19) $display("FAIL dbuf_new_seg: got %h want 19", seg); else passed++;
    checks++; if (pending !== 1'b0) $display("FAIL dbuf_cleared: got %b want 0", pending); else passed++;
  endtask

  task automatic test_coincident;
    logic [6:0] exp_g [4] = '{7'h21, 7'h46, 7'h03, 7'h08};
    for (int k = 0; k < 40 && n % 32 != 31; k++) @(negedge clk);
    load = 1'b1; digits_in = 16'hABCD;
    @(negedge clk);
    load = 1'b0;
    checks++; if (frame_tick !== 1'b1) $display("FAIL coin_tick: got %b want 1", frame_tick); else passed++;
    checks++; if (pending !== 1'b0) $display("FAIL coin_pending: got %b want 0", pending); else passed++;
    repeat (32) begin
      @(negedge clk);
      if ((n - 1) % 8 == 4) begin
        checks++;
        if (seg !== exp_g[(n - 1) % 32 / 8])
          $display("FAIL coin_glyph: got %h want %h", seg, exp_g[(n - 1) % 32 / 8]);
        else passed++;
      end
      checks++; if (pending !== 1'b0) $display("FAIL coin_pending_frame: got %b want 0", pending); else passed++;
    end
  endtask

  task automatic test_lz;
    logic [6:0] exp_g [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
    logic got = 1'b0;
    lz_en = 1'b1; load = 1'b1; digits_in = 16'h0050;
    @(negedge clk);
    load = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (frame_tick) got = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!got) $display("FAIL lz_tick_timeout: got no tick want tick"); else passed++;
    repeat (32) begin
      @(negedge clk);
      if ((n - 1) % 8 == 4) begin
        checks++;
        if (seg !== exp_g[(n - 1) % 32 / 8])
          $display("FAIL lz_on_glyph: got %h want %h", seg, exp_g[(n - 1) % 32 / 8]);
        else passed++;
      end
    end
    lz_en = 1'b0;
    repeat (32) begin
      @(negedge clk);
      if ((n - 1) % 32 == 28 || (n - 1) % 32 == 20) begin
        checks++; if (seg !== 7'h40) $display("FAIL lz_off_glyph: got %h want 40", seg); else passed++;
      end
    end
  endtask

  task automatic test_reset_abort;
    for (int k = 0; k < 40 && n % 32 != 5; k++) @(negedge clk);
    load = 1'b1; digits_in = 16'h9876;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      checks++; if (seg !== 7'h40) $display("FAIL abort_seg: got %h want 40", seg); else passed++;
      checks++; if (pending !== 1'b0) $display("FAIL abort_pending: got %b want 0", pending); else passed++;
    end
  endtask

`ifdef DISP_SCAN_DIMMING_EN
  task automatic test_dimming;
    int cnt [4];
    for (int b = 3; b <= 7; b += 4) begin
      bright = 3'(b);
      cnt = '{0, 0, 0, 0};
      repeat (32) begin
        @(negedge clk);
        if (dgt !== 4'hF) cnt[(n - 1) % 32 / 8]++;
      end
      for (int s = 0; s < 4; s++) begin
        checks++;
        if (cnt[s] != (b == 3 ? 3 : 6)) $display("FAIL dim_on_time: got %0d want %0d", cnt[s], b == 3 ? 3 : 6);
        else passed++;
      end
    end
    bright = 3'd7;
  endtask
`endif

  task automatic test_random;
    repeat (400) begin
      @(negedge clk);
      checks++; if (dgt !== m_dgt) $display("FAIL rand_dgt: got %b want %b", dgt, m_dgt); else passed++;
      checks++; if (seg !== m_seg) $display("FAIL rand_seg: got %h want %h", seg, m_seg); else passed++;
      checks++; if (pending !== m_pend) $display("FAIL rand_pending: got %b want %b", pending, m_pend); else passed++;
      checks++; if (frame_tick !== m_tick) $display("FAIL rand_tick: got %b want %b", frame_tick, m_tick); else passed++;
      load = $urandom_range(0, 7) == 0;
      digits_in = 16'($urandom);
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
      rst_n = $urandom_range(0, 149) != 0;
`ifdef DISP_SCAN_DIMMING_EN
      if ($urandom_range(0, 31) == 0) bright = 3'($urandom);
`endif
    end
    load = 1'b0; rst_n = 1'b1;
  endtask

  initial begin
    test_reset;
    test_scan;
    test_double_buffer;
    test_coincident;
    test_lz;
    test_reset_abort;
`ifdef DISP_SCAN_DIMMING_EN
    test_dimming;
`endif
    test_random;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/disp_scan_ctrl.md
DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles per digit slot (legal range 4..2^20).
REQ-002 SHALL have parameter BLANK_CYC, default 500, anti-ghost cycles at the start of each slot (legal range 1..SCAN_DIV-2).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port load  input  1  one-cycle strobe, capture digits_in.
REQ-006 SHALL have port digits_in  input  16  four hex nibbles, [3:0] is digit 0 (rightmost).
REQ-007 SHALL have port lz_en  input  1  leading-zero suppression enable, sampled every cycle.
REQ-008 SHALL have port dgt  output  4  active-low digit select; slot n drives bit n low only.
REQ-009 SHALL have port seg  output  7  active-low segments {g,f,e,d,c,b,a}.
REQ-010 SHALL have port pending  output  1  high while a loaded value awaits frame-boundary transfer.
REQ-011 SHALL have port frame_tick  output  1  one-cycle pulse at each slot 3->0 transition.

Function
REQ-012 SHALL count div 0..SCAN_DIV-1 and wrap; slot (2 bits) advances 0->1->2->3->0 on the cycle div wraps.
REQ-013 SHALL register dgt and seg; both update one cycle after the div/slot change that causes them.
REQ-014 SHALL drive dgt=4'b1111 while div<BLANK_CYC; otherwise dgt selects the current slot (slot 0 = 4'b1110, slot 3 = 4'b0111).
REQ-015 SHALL drive seg as the hex 0-F glyph of the active nibble for the current slot; seg=7'h7F when the digit is suppressed.
REQ-016 SHALL double-buffer: load=1 writes digits_in to a shadow register and sets pending; later loads before transfer overwrite the shadow register (last wins).
REQ-017 SHALL copy shadow to the active register and clear pending on the 3->0 slot transition; the displayed value never changes mid-frame.
REQ-018 SHALL, when load coincides with the 3->0 transition, copy digits_in straight into the active register and leave pending=0.
REQ-019 SHALL, with lz_en=1, suppress digit k (k=3,2,1) when it and all higher digits are zero; digit 0 is never suppressed.
REQ-020 SHALL assert frame_tick for exactly one cycle, coincident with the cycle the active register updates.

Reset
REQ-021 SHALL, when rst_n=0 at a clk edge, set div=0, slot=0, active=16'h0000, shadow=16'h0000, pending=0, frame_tick=0, dgt=4'b1111, seg=7'h7F.
REQ-022 SHALL treat reset mid-frame or mid-pending as abort: the shadow value is discarded and is not displayed after reset.
REQ-023 SHALL ignore load during any cycle where rst_n=0.

Configuration
REQ-024 SHALL compile brightness dimming in only when macro DISP_SCAN_DIMMING_EN is defined.
REQ-025 SHALL, with DISP_SCAN_DIMMING_EN defined, add input bright (3 bits); dgt is enabled only while (div-BLANK_CYC) < ((SCAN_DIV-BLANK_CYC)*(bright+1))/8, so bright=7 gives full on-time.
REQ-026 SHALL, without DISP_SCAN_DIMMING_EN, have no bright port and behave as bright=7.

Structure
REQ-027 SHALL place the seg glyph constants (SEG_0..SEG_F, SEG_BLANK=7'h7F) and DGT_OFF=4'b1111 in shared package disp_pkg.
REQ-028 SHALL instantiate one combinational sub-module seg7_hex (4-bit in, 7-bit active-low out) for glyph decode.
REQ-029 SHALL keep div, slot, shadow, active and pending in disp_scan_ctrl with no other sub-modules.

Verification (bench uses SCAN_DIV=8, BLANK_CYC=2)
REQ-030 SHALL check reset: hold rst_n=0 for 3 cycles then release -> dgt=4'b1111 and seg=7'h7F during reset; after release, slot 0 digit '0' (seg=7'h40) shows after blanking, dgt=4'b1110.
REQ-031 SHALL check scan order: run 32 cycles -> dgt sequence 1110,0111-ordered per slot each 8 cycles with 2-cycle 4'b1111 gaps, and a frame_tick every 32 cycles.
REQ-032 SHALL check double-buffering: load 16'h1234 mid-slot 1 -> pending=1, display still 0000 until the 3->0 transition, then slot 0 shows '4' (seg=7'h19) and pending=0.
REQ-033 SHALL check the coincident case: load 16'hABCD on the 3->0 cycle -> pending stays 0 and the next frame shows D,C,B,A.
REQ-034 SHALL check leading zeros: active 16'h0050, lz_en=1 -> slots 3 and 2 seg=7'h7F, slot 1 '5', slot 0 '0'; with lz_en=0, slot 3 shows '0'.
REQ-035 SHALL check dimming (DISP_SCAN_DIMMING_EN defined): bright=3 -> dgt low for 3 of the 6 post-blank cycles per slot; bright=7 -> low for all 6.
